vie_ifc_bridge: RTL
===================

VIE_IFC_BRIDGE -- requirements
Module: vie_ifc_bridge

Interface
REQ-001 Parameter DELAY_MASK, default 4'h0, masks the pseudo-random extra response delay (4'h0 gives fixed latency).
REQ-002 Parameter LFSR_SEED, default 8'h5A, is the delay LFSR value at reset.
REQ-003 clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 inst_ifc_i  input  72  request bus from the fetch stage:
- [71] req
- [70] wr
- [69:68] size
- [67:64] wstrb
- [63:32] addr
- [31:0] wdata
REQ-006 ifc_inst_o  output  34  response bus to the fetch stage:
- [33] addr_ok
- [32] data_ok
- [31:0] rdata
REQ-007 inst_sram_en  output  1  synchronous SRAM access enable.
REQ-008 inst_sram_wen  output  4  byte write enables.
REQ-009 inst_sram_addr  output  32  SRAM byte address.
REQ-010 inst_sram_wdata  output  32  SRAM write data.
REQ-011 inst_sram_rdata  input  32  SRAM read data, valid the cycle after en.

Function
REQ-012 The block SHALL have four states: S_IDLE, S_ACCESS, S_DELAY, S_RESP; only one transaction SHALL be outstanding at a time.
REQ-013 addr_ok SHALL be combinationally 1 exactly when the state is S_IDLE and resetn is 1.
REQ-014 A transaction SHALL be accepted in any cycle T where req and addr_ok are both 1.
REQ-015 In cycle T, inst_sram_en SHALL be 1, inst_sram_addr SHALL equal addr, and inst_sram_wdata SHALL equal wdata.
REQ-016 In cycle T, inst_sram_wen SHALL equal wstrb when wr=1 and 4'b0000 when wr=0.
REQ-017 Outside an accept cycle, inst_sram_en and inst_sram_wen SHALL be 0.
REQ-018 On accept, the state SHALL go S_IDLE->S_ACCESS, and D = LFSR[3:0] & DELAY_MASK SHALL be computed from the pre-advance LFSR value.
REQ-019 On accept, the LFSR SHALL advance once:
- feedback = L[7]^L[5]^L[4]^L[3]
- L <= {L[6:0], feedback}
- the LFSR SHALL not advance in any other cycle.
REQ-020 In S_ACCESS (cycle T+1), the response buffer SHALL capture inst_sram_rdata for reads and 32'h0 for writes, and the delay counter SHALL load D.
REQ-021 From S_ACCESS, the state SHALL go to S_RESP if D==0, otherwise to S_DELAY.
REQ-022 In S_DELAY, the counter SHALL decrement each cycle and the state SHALL go to S_RESP in the cycle the counter equals 1.
REQ-023 data_ok SHALL be 1 for exactly one cycle, in S_RESP at cycle T+2+D, with rdata equal to the captured buffer.
REQ-024 rdata SHALL hold the buffer value at all other times.
REQ-025 S_RESP SHALL always go to S_IDLE, so the earliest next accept is T+3+D.
REQ-026 Every accepted transaction SHALL receive exactly one data_ok; req deassertion after accept SHALL NOT cancel it.
REQ-027 Changes of inst_sram_rdata after T+1 SHALL NOT affect the returned rdata.
REQ-028 size SHALL be ignored, and addr SHALL be passed through unaligned and unmodified.

Reset
REQ-029 While resetn=0, all of the following SHALL hold immediately, regardless of clock:
- state = S_IDLE
- LFSR = LFSR_SEED
- delay counter = 0
- response buffer = 32'h0
- addr_ok = 0, data_ok = 0, inst_sram_en = 0, inst_sram_wen = 0
REQ-030 A reset asserted mid-transaction SHALL discard the pending response; no data_ok SHALL appear for it after release.
REQ-031 addr_ok SHALL be 1 in the first cycle after resetn rises.

Verification
REQ-032 DELAY_MASK=0; read addr 0xbfc00000 accepted at T; SRAM returns 0x3c1d0000 at T+1 -> at T: en=1, addr=0xbfc00000, wen=0; at T+2: data_ok=1 with rdata 0x3c1d0000, for one cycle only.
REQ-033 req held high continuously, DELAY_MASK=0 -> addr_ok=0 at T+1..T+2; next accept at T+3; one transaction per 3 cycles.
REQ-034 Write with wr=1, wstrb=4'b0011, addr 0x80000010, wdata 0x1234abcd -> at T: wen=4'b0011 and wdata=0x1234abcd; at T+2: data_ok=1 with rdata 0x00000000.
REQ-035 DELAY_MASK=4'hF, first two accepts after reset -> first data_ok at T+12 (D=0xA, LFSR 0x5A->0xB4); second data_ok at its accept+6 (D=4).
REQ-036 resetn pulsed low while in S_DELAY -> addr_ok, data_ok and en drop to 0 immediately; no stale data_ok after release; next accept uses D from LFSR=0x5A.
REQ-037 SRAM rdata changed to 0xdeadbeef at T+2 with DELAY_MASK=4'hF -> the returned rdata still equals the value captured at T+1.

Source files
------------

// File: rtl/vie_ifc_bridge.sv
// Fetch-stage request/response bridge onto a synchronous instruction SRAM.
// One transaction in flight, with optional LFSR-driven extra response delay.
module vie_ifc_bridge #(
  parameter logic [3:0] DELAY_MASK = 4'h0,
  parameter logic [7:0] LFSR_SEED  = 8'h5A
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [71:0] inst_ifc_i,
  output logic [33:0] ifc_inst_o,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DELAY  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]  r_state;
  logic [7:0]  r_lfsr;
  logic [3:0]  r_dly;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic [31:0] r_buf;

  logic        w_req;
  logic        w_wr;
  logic [3:0]  w_wstrb;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_addr_ok;
  logic        w_accept;
  logic        w_fb;
  logic        w_unused_size;

  assign w_req         = inst_ifc_i[71];
  assign w_wr          = inst_ifc_i[70];
  assign w_unused_size = ^inst_ifc_i[69:68];
  assign w_wstrb       = inst_ifc_i[67:64];
  assign w_addr        = inst_ifc_i[63:32];
  assign w_wdata       = inst_ifc_i[31:0];

  // Gating with resetn keeps addr_ok low for the whole reset, not just after the edge.
  assign w_addr_ok = (r_state == S_IDLE) && resetn;
  assign w_accept  = w_req && w_addr_ok;
  assign w_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  assign inst_sram_en    = w_accept;
  assign inst_sram_wen   = (w_accept && w_wr) ? w_wstrb : 4'b0000;
  assign inst_sram_addr  = w_addr;
  assign inst_sram_wdata = w_wdata;

  assign ifc_inst_o = {w_addr_ok, (r_state == S_RESP), r_buf};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_dly   <= 4'h0;
      r_cnt   <= 4'h0;
      r_wr    <= 1'b0;
      r_buf   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_ACCESS;
            r_dly   <= r_lfsr[3:0] & DELAY_MASK;
            r_wr    <= w_wr;
            r_lfsr  <= {r_lfsr[6:0], w_fb};
          end
        end
        S_ACCESS: begin
          // SRAM read data is only valid this one cycle; latch it now.
          r_buf   <= r_wr ? 32'h0 : inst_sram_rdata;
          r_cnt   <= r_dly;
          r_state <= (r_dly == 4'h0) ? S_RESP : S_DELAY;
        end
        S_DELAY: begin
          r_cnt <= r_cnt - 4'h1;
          if (r_cnt == 4'h1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
